// File: rtl/fb_scan_if.sv
// Scanner bus: frame RAM read port plus the pixel stream towards the LCD controller.
// The master side is the scanner; the slave side is RAM/LCD.
interface fb_scan_if #(
    parameter int XW = 8,
    parameter int YW = 9,
    parameter int AW = 17,
    parameter int DW = 16
);
    logic [AW-1:0] ram_rdaddr;
    logic [DW-1:0] ram_rddata;
    logic          pixelReady;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic [XW-1:0] xAddr;
    logic [YW-1:0] yAddr;

    modport master (
        output ram_rdaddr, pix_valid, pix_data, xAddr, yAddr,
        input  ram_rddata, pixelReady
    );

    modport slave (
        input  ram_rdaddr, pix_valid, pix_data, xAddr, yAddr,
        output ram_rddata, pixelReady
    );
endinterface

// File: rtl/fb_scan_ctrl.sv
// Framebuffer-to-LCD scanner: walks a window of the frame RAM in raster order and
// returns pixel data tagged with LCD coordinates, aligned to the RAM read latency.
module fb_scan_ctrl #(
    parameter int H_RES  = 240,
    parameter int V_RES  = 320,
    parameter int XW     = 8,
    parameter int YW     = 9,
    parameter int AW     = 17,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk50M,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cont,
    input  logic          mirror_x,
    input  logic          mirror_y,
    input  logic [XW-1:0] win_x0,
    input  logic [XW-1:0] win_x1,
    input  logic [YW-1:0] win_y0,
    input  logic [YW-1:0] win_y1,
    fb_scan_if.master     bus,
    output logic          busy,
    output logic          frame_start,
    output logic          frame_done,
    output logic          win_err
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    localparam int unsigned   NSTG   = RD_LAT + 1;
    localparam logic [XW:0]   H_LIM  = (XW+1)'(H_RES);
    localparam logic [YW:0]   V_LIM  = (YW+1)'(V_RES);
    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    state_t        state, state_nx;
    logic [XW-1:0] cx0, cx1, x;
    logic [YW-1:0] cy0, cy1, y;
    logic          mx, my, first;
    logic          win_bad;
    logic [XW-1:0] ex0, ex1;
    logic [YW-1:0] ey0, ey1;
    logic          issue, last, latch, pipe_busy;
    logic [XW-1:0] xm;
    logic [YW-1:0] ym;
    logic [AW-1:0] addr;

    // Tag pipeline: stage k holds the pixel whose address went out k+1 cycles ago.
    logic [RD_LAT:0] pv, plast;
    logic [XW-1:0]   px [NSTG];
    logic [YW-1:0]   py [NSTG];

    always_comb begin
        win_bad = (win_x0 > win_x1) || (win_y0 > win_y1) ||
                  ({1'b0, win_x1} >= H_LIM) || ({1'b0, win_y1} >= V_LIM);
        ex0 = win_bad ? '0     : win_x0;
        ex1 = win_bad ? X_LAST : win_x1;
        ey0 = win_bad ? '0     : win_y0;
        ey1 = win_bad ? Y_LAST : win_y1;
    end

    always_comb begin
        xm   = mx ? X_LAST - x : x;
        ym   = my ? Y_LAST - y : y;
        addr = AW'(ym) * AW'(H_RES) + AW'(xm);
    end

    assign pipe_busy = |pv;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk50M) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // A continuous restart re-latches on the last issue itself, so the next frame
    // issues on the following cycle without passing through DRAIN.
    always_comb begin
        state_nx = state;
        latch    = 1'b0;
        issue    = 1'b0;
        last     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    latch    = 1'b1;
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                issue = bus.pixelReady;
                last  = bus.pixelReady && (x == cx1) && (y == cy1);
                if (last) begin
                    if (cont) latch    = 1'b1;
                    else      state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!pipe_busy) begin
                    if (cont) begin
                        latch    = 1'b1;
                        state_nx = SCAN;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk50M) begin
        if (!rst_n) begin
            cx0            <= '0;
            cx1            <= '0;
            cy0            <= '0;
            cy1            <= '0;
            x              <= '0;
            y              <= '0;
            mx             <= 1'b0;
            my             <= 1'b0;
            first          <= 1'b0;
            win_err        <= 1'b0;
            frame_start    <= 1'b0;
            frame_done     <= 1'b0;
            pv             <= '0;
            plast          <= '0;
            for (int unsigned k = 0; k < NSTG; k++) begin
                px[k] <= '0;
                py[k] <= '0;
            end
            bus.ram_rdaddr <= '0;
            bus.pix_valid  <= 1'b0;
            bus.pix_data   <= '0;
            bus.xAddr      <= '0;
            bus.yAddr      <= '0;
        end else begin
            if (latch) begin
                cx0     <= ex0;
                cx1     <= ex1;
                cy0     <= ey0;
                cy1     <= ey1;
                x       <= ex0;
                y       <= ey0;
                mx      <= mirror_x;
                my      <= mirror_y;
                win_err <= win_bad;
                first   <= 1'b1;
            end else if (issue) begin
                if (x == cx1) begin
                    x <= cx0;
                    y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
                first <= 1'b0;
            end

            // frame_start is aligned with ram_rdaddr carrying the window origin.
            frame_start <= issue && first;
            if (issue) bus.ram_rdaddr <= addr;

            pv    <= {pv[RD_LAT-1:0], issue};
            plast <= {plast[RD_LAT-1:0], last};
            px[0] <= x;
            py[0] <= y;
            for (int unsigned k = 1; k < NSTG; k++) begin
                px[k] <= px[k-1];
                py[k] <= py[k-1];
            end

            bus.pix_valid <= pv[RD_LAT];
            frame_done    <= pv[RD_LAT] && plast[RD_LAT];
            if (pv[RD_LAT]) begin
                bus.pix_data <= DW'(bus.ram_rddata);
                bus.xAddr    <= px[RD_LAT];
                bus.yAddr    <= py[RD_LAT];
            end
        end
    end
endmodule
